// File: rtl/player_countdown_if.sv
// Signal bundle between the mode controller (master) and one player's countdown timer (slave).
// set_time/count are levels, inc_min/inc_sec are single-cycle pulses, tick is a single-cycle
// pulse per decrement; there is no back-pressure, so every pulse is consumed in its cycle.
interface player_countdown_if;
  logic       set_time;
  logic       count;
  logic       inc_min;
  logic       inc_sec;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       expired;
  logic       tick;
  logic [2:0] dbgState;

  modport master (
    output set_time, count, inc_min, inc_sec,
    input  min_tens, min_ones, sec_tens, sec_ones, running, expired, tick, dbgState
  );

  modport slave (
    input  set_time, count, inc_min, inc_sec,
    output min_tens, min_ones, sec_tens, sec_ones, running, expired, tick, dbgState
  );
endinterface

// File: rtl/player_countdown.sv
// Per-player MM:SS BCD countdown for the chess clock: time entry in SET, one decrement per
// prescaler period in RUN, sticky expiry at 00:00.
module player_countdown #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int DEFAULT_MIN = 5,
  parameter int MAX_MIN     = 99
) (
  input logic               clk,
  input logic               reset,
  player_countdown_if.slave pc
);

  localparam int            PERIOD      = CLK_FREQ / TICK_HZ;
  localparam int            PW          = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PRESC_TERM  = PW'(PERIOD - 1);
  localparam logic [3:0]    DEF_TENS    = 4'(DEFAULT_MIN / 10);
  localparam logic [3:0]    DEF_ONES    = 4'(DEFAULT_MIN % 10);
  localparam logic [6:0]    MAX_MIN_BIN = 7'(MAX_MIN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET     = 3'd1,
    RUN     = 3'd2,
    PAUSE   = 3'd3,
    EXPIRED = 3'd4
  } stateT;

  stateT         state, stateNext;
  logic          setMeta, setSync, countMeta, countSync;
  logic [PW-1:0] presc;
  logic [3:0]    minTens, minOnes, secTens, secOnes;
  logic [3:0]    minTensNext, minOnesNext, secTensNext, secOnesNext;
  logic [6:0]    minBin;
  logic          timeIsZero, atOneSec, tickNow;

  // Two-flop synchronisers on the controller's mode levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      setMeta   <= 1'b0;
      setSync   <= 1'b0;
      countMeta <= 1'b0;
      countSync <= 1'b0;
    end else begin
      setMeta   <= pc.set_time;
      setSync   <= setMeta;
      countMeta <= pc.count;
      countSync <= countMeta;
    end
  end

  assign minBin     = 7'(minTens) * 7'd10 + 7'(minOnes);
  assign timeIsZero = (minTens == 4'd0) && (minOnes == 4'd0) && (secTens == 4'd0) && (secOnes == 4'd0);
  assign atOneSec   = (minTens == 4'd0) && (minOnes == 4'd0) && (secTens == 4'd0) && (secOnes == 4'd1);
  // A zero time never ticks; RUN at 00:00 goes straight to EXPIRED instead.
  assign tickNow    = (state == RUN) && (presc == PRESC_TERM) && !timeIsZero;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (countSync) stateNext = RUN;
               else if (setSync) stateNext = SET;
      SET:     if (countSync) stateNext = RUN;
               else if (!setSync) stateNext = PAUSE;
      RUN:     if (timeIsZero || (tickNow && atOneSec)) stateNext = EXPIRED;
               else if (!countSync) stateNext = PAUSE;
      PAUSE:   if (countSync) stateNext = RUN;
               else if (setSync) stateNext = SET;
      EXPIRED: if (setSync) stateNext = SET;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    minTensNext = minTens;
    minOnesNext = minOnes;
    secTensNext = secTens;
    secOnesNext = secOnes;
    if (state == SET) begin
      if (pc.inc_min) begin
        if (minBin >= MAX_MIN_BIN) begin
          minTensNext = 4'd0;
          minOnesNext = 4'd0;
        end else if (minOnes == 4'd9) begin
          minOnesNext = 4'd0;
          minTensNext = minTens + 4'd1;
        end else begin
          minOnesNext = minOnes + 4'd1;
        end
      end
      // Seconds wrap 59 -> 00 on their own; minutes are never carried into.
      if (pc.inc_sec) begin
        if (secTens == 4'd5 && secOnes == 4'd9) begin
          secTensNext = 4'd0;
          secOnesNext = 4'd0;
        end else if (secOnes == 4'd9) begin
          secOnesNext = 4'd0;
          secTensNext = secTens + 4'd1;
        end else begin
          secOnesNext = secOnes + 4'd1;
        end
      end
    end else if (tickNow) begin
      if (secOnes != 4'd0) begin
        secOnesNext = secOnes - 4'd1;
      end else begin
        secOnesNext = 4'd9;
        if (secTens != 4'd0) begin
          secTensNext = secTens - 4'd1;
        end else begin
          secTensNext = 4'd5;
          if (minOnes != 4'd0) begin
            minOnesNext = minOnes - 4'd1;
          end else begin
            minOnesNext = 4'd9;
            minTensNext = minTens - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      minTens <= DEF_TENS;
      minOnes <= DEF_ONES;
      secTens <= 4'd0;
      secOnes <= 4'd0;
    end else begin
      state   <= stateNext;
      minTens <= minTensNext;
      minOnes <= minOnesNext;
      secTens <= secTensNext;
      secOnes <= secOnesNext;
      // Prescaler survives a pause so a resumed second is not restarted.
      case (state)
        RUN:     presc <= (presc == PRESC_TERM) ? '0 : presc + 1'b1;
        PAUSE:   presc <= presc;
        default: presc <= '0;
      endcase
    end
  end

  assign pc.min_tens = minTens;
  assign pc.min_ones = minOnes;
  assign pc.sec_tens = secTens;
  assign pc.sec_ones = secOnes;
  assign pc.running  = (state == RUN);
  assign pc.expired  = (state == EXPIRED);
  assign pc.tick     = tickNow;
  assign pc.dbgState = state;

endmodule
